// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM timebase counter.
//   pwm_state_t     : FSM state encoding (IDLE, RUN, PAUSE)
//   PWM_WIDTH       : default counter/period width (must match pwm_gen)
//   PWM_PRESC_WIDTH : default prescaler divider width
//   CNT_UP/CNT_DOWN : values of the up_down input
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } pwm_state_t;

  localparam int PWM_WIDTH       = 16;
  localparam int PWM_PRESC_WIDTH = 8;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler for the PWM timebase: produces one tick every
// presc_max+1 enabled clk cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the divider count (wins over en)
//   en         : count enable; when low the divider count holds
//   presc_max  : terminal value of the divider count
//   tick       : combinational, high in the cycle the count sits at presc_max
//                while enabled
module pwm_prescaler #(
  parameter int PRESC_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [PRESC_WIDTH-1:0] presc_max,
  output logic                   tick
);

  logic [PRESC_WIDTH-1:0] presc_cnt;

  assign tick = en && (presc_cnt == presc_max);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
    end else if (clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      if (tick) presc_cnt <= '0;
      else      presc_cnt <= presc_cnt + PRESC_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_counter.sv
// Timebase counter feeding pwm_gen's count_val input. Counts 0..period
// (period+1 ticks) up or down, with a clock prescaler. period, prescale and
// up_down are shadowed: they are latched on start and on every wrap only.
// Optional build macro: PWM_CNT_ONESHOT_EN adds a shadowed one_shot input;
// when active the counter stops in IDLE after its first wrap and only
// restarts after cnt_en is seen low and then high again.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   cnt_en      : run enable; low pauses counting
//   cnt_rst     : synchronous clear back to IDLE
//   up_down     : 1 = count up, 0 = count down (shadowed)
//   period      : terminal count (shadowed)
//   prescale    : tick every prescale+1 clk cycles (shadowed)
//   one_shot    : stop after first wrap (shadowed, PWM_CNT_ONESHOT_EN only)
//   count_val   : registered count to pwm_gen
//   period_done : one-cycle pulse coincident with the wrapped count_val
//   running     : high while in RUN
module pwm_counter
  import pwm_pkg::*;
#(
  parameter int WIDTH       = PWM_WIDTH,
  parameter int PRESC_WIDTH = PWM_PRESC_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cnt_en,
  input  logic                   cnt_rst,
  input  logic                   up_down,
  input  logic [WIDTH-1:0]       period,
  input  logic [PRESC_WIDTH-1:0] prescale,
`ifdef PWM_CNT_ONESHOT_EN
  input  logic                   one_shot,
`endif
  output logic [WIDTH-1:0]       count_val,
  output logic                   period_done,
  output logic                   running
);

  pwm_state_t             state;
  logic [WIDTH-1:0]       act_period;
  logic [PRESC_WIDTH-1:0] act_prescale;
  logic                   act_dir;
  logic                   tick;
  logic                   at_term;
  logic                   start_ok;
  logic                   stop_now;
  logic [WIDTH-1:0]       load_val;

  // The prescaler only advances while truly running; IDLE keeps it cleared
  // so a fresh start always begins a full prescale interval.
  pwm_prescaler #(
    .PRESC_WIDTH(PRESC_WIDTH)
  ) u_presc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_rst || (state == IDLE)),
    .en       ((state == RUN) && cnt_en && !cnt_rst),
    .presc_max(act_prescale),
    .tick     (tick)
  );

  // Terminal value depends on the active direction; wrapping is detected by
  // comparison so the max period never relies on arithmetic overflow.
  assign at_term = (act_dir == CNT_UP) ? (count_val == act_period)
                                       : (count_val == '0);

  // Start/reload value follows the newly latched direction and period.
  assign load_val = (up_down == CNT_UP) ? '0 : period;

`ifdef PWM_CNT_ONESHOT_EN
  logic act_one_shot;
  logic armed;

  assign start_ok = armed;
  assign stop_now = act_one_shot;

  // Armed by any cycle with cnt_en low; disarmed when a one-shot completes,
  // so holding cnt_en high cannot retrigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b1;
      act_one_shot <= 1'b0;
    end else begin
      if (!cnt_en) begin
        armed <= 1'b1;
      end else if (!cnt_rst && (state == RUN) && tick && at_term && act_one_shot) begin
        armed <= 1'b0;
      end
      if (!cnt_rst && (((state == IDLE) && cnt_en && armed) ||
                       ((state == RUN) && cnt_en && tick && at_term))) begin
        act_one_shot <= one_shot;
      end
    end
  end
`else
  assign start_ok = 1'b1;
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count_val    <= '0;
      period_done  <= 1'b0;
      running      <= 1'b0;
      act_period   <= '0;
      act_prescale <= '0;
      act_dir      <= 1'b0;
    end else if (cnt_rst) begin
      state       <= IDLE;
      count_val   <= '0;
      period_done <= 1'b0;
      running     <= 1'b0;
    end else begin
      period_done <= 1'b0;
      unique case (state)
        IDLE: begin
          count_val <= '0;
          if (cnt_en && start_ok) begin
            act_period   <= period;
            act_prescale <= prescale;
            act_dir      <= up_down;
            count_val    <= load_val;
            state        <= RUN;
            running      <= 1'b1;
          end
        end
        RUN: begin
          if (!cnt_en) begin
            state   <= PAUSE;
            running <= 1'b0;
          end else if (tick) begin
            if (at_term) begin
              period_done  <= 1'b1;
              act_period   <= period;
              act_prescale <= prescale;
              act_dir      <= up_down;
              if (stop_now) begin
                count_val <= '0;
                state     <= IDLE;
                running   <= 1'b0;
              end else begin
                count_val <= load_val;
              end
            end else if (act_dir == CNT_UP) begin
              count_val <= count_val + WIDTH'(1);
            end else begin
              count_val <= count_val - WIDTH'(1);
            end
          end
        end
        PAUSE: begin
          // Resume without relatching shadows; counting restarts next cycle.
          if (cnt_en) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_counter.sv
module tb_pwm_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cnt_en = 1'b0;
  logic        cnt_rst = 1'b0;
  logic        up_down = 1'b1;
  logic [15:0] period = '0;
  logic [7:0]  prescale = '0;
  logic        one_shot = 1'b0;
  logic [15:0] count_val;
  logic        period_done;
  logic        running;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  pwm_counter #(.WIDTH(16), .PRESC_WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_en     (cnt_en),
    .cnt_rst    (cnt_rst),
    .up_down    (up_down),
    .period     (period),
    .prescale   (prescale),
`ifdef PWM_CNT_ONESHOT_EN
    .one_shot   (one_shot),
`endif
    .count_val  (count_val),
    .period_done(period_done),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Behavioural reference: mode 0 idle, 1 run, 2 pause. Counting is tracked
  // as a tick phase within the prescale interval and a position in the period.
  int  m_mode = 0;
  int  m_cnt = 0;
  int  m_phase = 0;
  bit  m_pd = 0;
  int  m_per = 0;
  int  m_psc = 0;
  bit  m_up = 0;
  bit  m_os = 0;
  bit  m_arm = 1;

  task automatic m_latch();
    m_per = int'(period);
    m_psc = int'(prescale);
    m_up  = up_down;
`ifdef PWM_CNT_ONESHOT_EN
    m_os  = one_shot;
`else
    m_os  = 1'b0;
`endif
    m_cnt = m_up ? 0 : m_per;
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_mode = 0; m_cnt = 0; m_phase = 0; m_pd = 0;
      m_per = 0; m_psc = 0; m_up = 0; m_os = 0; m_arm = 1;
    end else begin
      bit was_os;
      was_os = 0;
      m_pd = 0;
      if (cnt_rst) begin
        m_cnt = 0; m_phase = 0; m_mode = 0;
      end else if (m_mode == 0) begin
        if (cnt_en && m_arm) begin
          m_latch();
          m_phase = 0;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (!cnt_en) begin
          m_mode = 2;
        end else if (m_phase < m_psc) begin
          m_phase++;
        end else begin
          m_phase = 0;
          if (m_cnt == (m_up ? m_per : 0)) begin
            m_pd = 1;
            was_os = m_os;
            m_latch();
            if (was_os) begin
              m_cnt = 0; m_mode = 0; m_arm = 0;
            end
          end else begin
            m_cnt = m_up ? m_cnt + 1 : m_cnt - 1;
          end
        end
      end else begin
        if (cnt_en) m_mode = 1;
      end
      if (!cnt_en) m_arm = 1;
    end
  end

  // Cycle-by-cycle comparison against the reference, just after each edge.
  initial forever begin
    @(posedge clk);
    #1;
    if (chk_on) begin
      vectors++;
      if (count_val !== m_cnt[15:0] || period_done !== m_pd || running !== (m_mode == 1)) begin
        miscompares++;
        $display("FAIL model t=%0t: got cnt=%0d pd=%0b run=%0b, need cnt=%0d pd=%0b run=%0b",
                 $time, count_val, period_done, running, m_cnt, m_pd, (m_mode == 1));
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(string name, int exp_cnt, bit exp_pd, bit exp_run);
    vectors++;
    if (count_val !== exp_cnt[15:0] || period_done !== exp_pd || running !== exp_run) begin
      miscompares++;
      $display("FAIL %s: got cnt=%0d pd=%0b run=%0b, need cnt=%0d pd=%0b run=%0b",
               name, count_val, period_done, running, exp_cnt, exp_pd, exp_run);
    end
  endtask

  initial begin
    step(2);
    expect_out("reset", 0, 0, 0);
    rst_n = 1'b1;
    chk_on = 1'b1;
    step(1);
    expect_out("idle_hold", 0, 0, 0);

    // Up count, period 9, with a pause at 6 and a mid-period period write.
    period = 16'd9; prescale = 8'd0; up_down = 1'b1; cnt_en = 1'b1;
    step(1); expect_out("start_up", 0, 0, 1);
    step(6); expect_out("up_6", 6, 0, 1);
    cnt_en = 1'b0;
    step(1); expect_out("pause_enter", 6, 0, 0);
    step(3); expect_out("pause_hold", 6, 0, 0);
    cnt_en = 1'b1;
    step(1); expect_out("resume", 6, 0, 1);
    step(1); expect_out("resume_7", 7, 0, 1);
    step(2); expect_out("up_9", 9, 0, 1);
    step(1); expect_out("wrap_9", 0, 1, 1);
    step(2); expect_out("up_2", 2, 0, 1);
    period = 16'd4;
    step(7); expect_out("shadow_ignored", 9, 0, 1);
    step(1); expect_out("wrap_relatch", 0, 1, 1);
    step(4); expect_out("new_term_4", 4, 0, 1);
    step(1); expect_out("wrap_4", 0, 1, 1);

    // cnt_rst on the wrap tick suppresses the wrap and its pulse.
    step(4); expect_out("pre_rst", 4, 0, 1);
    cnt_rst = 1'b1;
    step(1); expect_out("rst_on_wrap", 0, 0, 0);
    cnt_rst = 1'b0;
    step(1); expect_out("rerun", 0, 0, 1);

    // Switch to down, period 5, taking effect at the next wrap.
    up_down = 1'b0; period = 16'd5;
    step(4); expect_out("up_before_down", 4, 0, 1);
    step(1); expect_out("down_load", 5, 1, 1);
    step(5); expect_out("down_0", 0, 0, 1);
    step(1); expect_out("down_reload", 5, 1, 1);

    // Prescale 2, period 3, back to up (down reload loads 0).
    up_down = 1'b1; period = 16'd3; prescale = 8'd2;
    step(5); expect_out("down_end", 0, 0, 1);
    step(1); expect_out("down_to_up", 0, 1, 1);
    step(2); expect_out("presc_hold", 0, 0, 1);
    step(1); expect_out("presc_1", 1, 0, 1);
    step(6); expect_out("presc_3", 3, 0, 1);
    step(3); expect_out("presc_wrap", 0, 1, 1);
    period = 16'd0; prescale = 8'd0;
    step(12); expect_out("presc_wrap12", 0, 1, 1);
    step(1); expect_out("period0_a", 0, 1, 1);
    step(1); expect_out("period0_b", 0, 1, 1);

    // Max period counting down from the top value.
    cnt_rst = 1'b1;
    step(1); expect_out("rst_idle", 0, 0, 0);
    cnt_rst = 1'b0; up_down = 1'b0; period = 16'hFFFF;
    step(1); expect_out("max_load", 65535, 0, 1);
    step(1); expect_out("max_dec", 65534, 0, 1);

`ifdef PWM_CNT_ONESHOT_EN
    cnt_rst = 1'b1; cnt_en = 1'b0;
    step(1);
    cnt_rst = 1'b0; one_shot = 1'b1; period = 16'd3; up_down = 1'b1; cnt_en = 1'b1;
    step(1); expect_out("os_start", 0, 0, 1);
    step(3); expect_out("os_3", 3, 0, 1);
    step(1); expect_out("os_done", 0, 1, 0);
    step(2); expect_out("os_stay_idle", 0, 0, 0);
    cnt_en = 1'b0;
    step(1);
    one_shot = 1'b0; cnt_en = 1'b1;
    step(1); expect_out("os_rearm", 0, 0, 1);
`endif

    // Randomized phase: small periods/prescales, random shadow writes,
    // pauses and clears, checked against the reference every cycle.
    for (int i = 0; i < 4000; i++) begin
      cnt_en  = ($urandom_range(0, 99) < 92);
      cnt_rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 9) == 0) begin
        period   = 16'($urandom_range(0, 12));
        prescale = 8'($urandom_range(0, 3));
        up_down  = 1'($urandom_range(0, 1));
`ifdef PWM_CNT_ONESHOT_EN
        one_shot = ($urandom_range(0, 9) == 0);
`endif
      end
      step(1);
    end

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
